// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and its storage array.
package mem_pkg;

    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 32;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // True when a word address falls inside an array of the given depth.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
        return int'({{(32-ADDR_W){1'b0}}, addr}) < depth;
    endfunction

endpackage

// File: rtl/ram_512x32.sv
// Synchronous single-port storage array. Read data is registered and only
// changes on an enabled read, so it naturally holds between reads.
module ram_512x32
    import mem_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;

    assign idx = addr[IDX_W-1:0];

    // Single port: an enabled cycle is either a write or a registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= din;
            end else begin
                dout <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: accepts one read or write in IDLE, waits LATENCY cycles,
// performs the array access, then pulses done for one cycle.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | ready; a request latched here starts a transaction
//  WAIT   | inserting wait cycles, counter decrements once per cycle
//  ACCESS | array is read or written at the edge leaving this state
//  DONE   | done pulse visible; no new request accepted here
module memory_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 512
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              req_err
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              op_read;
    logic              rd_zero;
    logic              hit;
    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    // Out-of-range addresses never touch the array; reads of them return zero.
    assign hit    = addr_in_range(addr_q, DEPTH);
    assign ram_en = (state == ACCESS) && hit;
    assign ram_we = ram_en && !op_read;

    // rd_zero masks the stale array output after reset and after an
    // out-of-range read, without needing a reset on the array itself.
    assign rd_data = rd_zero ? '0 : ram_q;

    ram_512x32 #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (addr_q),
        .din  (data_q),
        .dout (ram_q)
    );

    // Request sequencing: latch, wait, access, completion pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_read <= 1'b0;
            rd_zero <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            req_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (read || write) begin
                        addr_q  <= mar_addr;
                        data_q  <= wr_data;
                        op_read <= read;
                        req_err <= read && write;
                        busy    <= 1'b1;
                        cnt     <= LAT;
                        state   <= (LAT == '0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (op_read) begin
                        rd_zero <= !hit;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (LATENCY 2, 0 and 1 with a
// 256-word array) checked against a word-level model of the memory.
module tb_memory_responder;

    localparam int LAT_OF [3] = '{2, 0, 1};
    localparam int DEP_OF [3] = '{512, 512, 256};

    typedef struct {
        int          done_at;
        int          done_cnt;
        int          busy_cnt;
        int          err_cnt;
        bit          hold_ok;
        logic [31:0] rd_final;
    } obs_t;

    logic        clk;
    logic        clr     [3];
    logic [8:0]  addr    [3];
    logic [31:0] wdat    [3];
    logic        read    [3];
    logic        write   [3];
    logic [31:0] rd_data [3];
    logic        busy    [3];
    logic        done    [3];
    logic        req_err [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl     [3][512];
    bit          known   [3][512];
    logic [31:0] last_rd [3];

    memory_responder #(.LATENCY(2), .DEPTH(512)) dut0 (
        .clk(clk), .clr(clr[0]), .mar_addr(addr[0]), .wr_data(wdat[0]),
        .read(read[0]), .write(write[0]), .rd_data(rd_data[0]),
        .busy(busy[0]), .done(done[0]), .req_err(req_err[0]));

    memory_responder #(.LATENCY(0), .DEPTH(512)) dut1 (
        .clk(clk), .clr(clr[1]), .mar_addr(addr[1]), .wr_data(wdat[1]),
        .read(read[1]), .write(write[1]), .rd_data(rd_data[1]),
        .busy(busy[1]), .done(done[1]), .req_err(req_err[1]));

    memory_responder #(.LATENCY(1), .DEPTH(256)) dut2 (
        .clk(clk), .clr(clr[2]), .mar_addr(addr[2]), .wr_data(wdat[2]),
        .read(read[2]), .write(write[2]), .rd_data(rd_data[2]),
        .busy(busy[2]), .done(done[2]), .req_err(req_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a read returns the stored word (0 when out of range) and
    // becomes the held output; a lone in-range write updates the word.
    function automatic logic [31:0] model_step(input int d, input bit rd, input bit wr,
                                               input logic [8:0] a, input logic [31:0] wd);
        int ai = int'(a);
        if (rd) begin
            last_rd[d] = (ai < DEP_OF[d]) ? mdl[d][ai] : 32'h0;
        end else if (wr && ai < DEP_OF[d]) begin
            mdl[d][ai]   = wd;
            known[d][ai] = 1'b1;
        end
        return last_rd[d];
    endfunction

    // Issue one request from IDLE and observe outputs for 20 cycles.
    // Sample j is taken j cycles after the accepting edge.
    task automatic do_req(input int d, input bit rd, input bit wr, input logic [8:0] a,
                          input logic [31:0] wd, output obs_t o);
        logic [31:0] prev;
        @(negedge clk);
        prev = rd_data[d];
        read[d] = rd; write[d] = wr; addr[d] = a; wdat[d] = wd;
        @(posedge clk);
        @(negedge clk);
        read[d] = 1'b0; write[d] = 1'b0;
        o.done_at = -1; o.done_cnt = 0; o.busy_cnt = 0; o.err_cnt = 0;
        o.hold_ok = 1'b1; o.rd_final = '0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            if (busy[d] === 1'b1) o.busy_cnt++;
            if (req_err[d] === 1'b1) o.err_cnt++;
            if (done[d] === 1'b1) begin
                o.done_cnt++;
                if (o.done_at < 0) begin
                    o.done_at  = j;
                    o.rd_final = rd_data[d];
                end
            end
            if ((o.done_at < 0 || !rd) && rd_data[d] !== prev) o.hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                total++;
                if ({rd_data[d], busy[d], done[d], req_err[d]} !== 35'h0) begin
                    bad++;
                    $display("FAIL reset d%0d: got rd=%0h busy=%0b done=%0b err=%0b want all 0",
                             d, rd_data[d], busy[d], done[d], req_err[d]);
                end
            end
        end
        @(posedge clk);
        #2;
        for (int d = 0; d < 3; d++) clr[d] = 1'b1;
    endtask

    task automatic test_default_read();
        obs_t o;
        logic [31:0] exp;
        do_req(0, 0, 1, 9'h005, 32'hDEADBEEF, o);
        void'(model_step(0, 0, 1, 9'h005, 32'hDEADBEEF));
        total++;
        if (o.done_at !== 3) begin bad++; $display("FAIL lat2 write latency: got %0d want 3", o.done_at); end
        do_req(0, 1, 0, 9'h005, 32'h0, o);
        exp = model_step(0, 1, 0, 9'h005, 32'h0);
        total++;
        if (o.done_at !== 3) begin bad++; $display("FAIL lat2 read latency: got %0d want 3", o.done_at); end
        total++;
        if (o.busy_cnt !== 3) begin bad++; $display("FAIL lat2 busy cycles: got %0d want 3", o.busy_cnt); end
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL lat2 read data: got %0h want %0h", o.rd_final, exp); end
    endtask

    task automatic test_zero_latency();
        obs_t o;
        logic [31:0] exp;
        do_req(1, 0, 1, 9'h1FF, 32'h12345678, o);
        void'(model_step(1, 0, 1, 9'h1FF, 32'h12345678));
        total++;
        if (o.done_at !== 1) begin bad++; $display("FAIL lat0 write latency: got %0d want 1", o.done_at); end
        do_req(1, 1, 0, 9'h1FF, 32'h0, o);
        exp = model_step(1, 1, 0, 9'h1FF, 32'h0);
        total++;
        if (o.done_at !== 1) begin bad++; $display("FAIL lat0 read latency: got %0d want 1", o.done_at); end
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL lat0 read data: got %0h want %0h", o.rd_final, exp); end
    endtask

    task automatic test_simultaneous();
        obs_t o;
        logic [31:0] exp;
        do_req(0, 0, 1, 9'h010, 32'h0000AAAA, o);
        void'(model_step(0, 0, 1, 9'h010, 32'h0000AAAA));
        do_req(0, 1, 1, 9'h010, 32'hFFFFFFFF, o);
        exp = model_step(0, 1, 1, 9'h010, 32'hFFFFFFFF);
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL both read data: got %0h want %0h", o.rd_final, exp); end
        total++;
        if (o.err_cnt !== 1) begin bad++; $display("FAIL both req_err pulses: got %0d want 1", o.err_cnt); end
        do_req(0, 1, 0, 9'h010, 32'h0, o);
        exp = model_step(0, 1, 0, 9'h010, 32'h0);
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL both write dropped: got %0h want %0h", o.rd_final, exp); end
    endtask

    task automatic test_busy_ignore();
        obs_t o;
        logic [31:0] exp;
        int nd;
        do_req(0, 0, 1, 9'h020, 32'h13572468, o);
        void'(model_step(0, 0, 1, 9'h020, 32'h13572468));
        @(negedge clk);
        addr[0] = 9'h020; read[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read[0] = 1'b0; write[0] = 1'b1; wdat[0] = 32'hBAD0BAD0;
        exp = model_step(0, 1, 0, 9'h020, 32'h0);
        nd = 0;
        for (int j = 0; j < 15; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 2) write[0] = 1'b0;
            if (done[0] === 1'b1) nd++;
        end
        total++;
        if (nd !== 1) begin bad++; $display("FAIL busy done count: got %0d want 1", nd); end
        total++;
        if (rd_data[0] !== exp) begin bad++; $display("FAIL busy read data: got %0h want %0h", rd_data[0], exp); end
        do_req(0, 1, 0, 9'h020, 32'h0, o);
        exp = model_step(0, 1, 0, 9'h020, 32'h0);
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL busy array kept: got %0h want %0h", o.rd_final, exp); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic [31:0] exp;
        int nd;
        do_req(0, 0, 1, 9'h030, 32'h11111111, o);
        void'(model_step(0, 0, 1, 9'h030, 32'h11111111));
        @(negedge clk);
        addr[0] = 9'h030; wdat[0] = 32'h5A5A5A5A; write[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write[0] = 1'b0;
        clr[0] = 1'b0;
        last_rd[0] = 32'h0;
        #1;
        total++;
        if ({rd_data[0], busy[0], done[0], req_err[0]} !== 35'h0) begin
            bad++;
            $display("FAIL mid reset outputs: got rd=%0h busy=%0b done=%0b err=%0b want all 0",
                     rd_data[0], busy[0], done[0], req_err[0]);
        end
        nd = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (done[0] === 1'b1) nd++;
        end
        @(posedge clk);
        #2;
        clr[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (done[0] === 1'b1) nd++;
        end
        total++;
        if (nd !== 0) begin bad++; $display("FAIL mid reset done seen: got %0d want 0", nd); end
        do_req(0, 1, 0, 9'h030, 32'h0, o);
        exp = model_step(0, 1, 0, 9'h030, 32'h0);
        total++;
        if (o.done_at !== 3) begin bad++; $display("FAIL post reset latency: got %0d want 3", o.done_at); end
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL post reset data: got %0h want %0h", o.rd_final, exp); end
    endtask

    task automatic test_hold();
        obs_t o;
        logic [31:0] exp;
        do_req(0, 1, 0, 9'h005, 32'h0, o);
        exp = model_step(0, 1, 0, 9'h005, 32'h0);
        do_req(0, 0, 1, 9'h040, 32'h76543210, o);
        void'(model_step(0, 0, 1, 9'h040, 32'h76543210));
        total++;
        if (o.hold_ok !== 1'b1) begin bad++; $display("FAIL hold during write: got %0b want 1", o.hold_ok); end
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL hold after write: got %0h want %0h", o.rd_final, exp); end
    endtask

    task automatic test_out_of_range();
        obs_t o;
        logic [31:0] exp;
        do_req(2, 0, 1, 9'h0AB, 32'h0F0F0F0F, o);
        void'(model_step(2, 0, 1, 9'h0AB, 32'h0F0F0F0F));
        do_req(2, 0, 1, 9'h1AB, 32'hCAFEF00D, o);
        void'(model_step(2, 0, 1, 9'h1AB, 32'hCAFEF00D));
        total++;
        if (o.done_cnt !== 1) begin bad++; $display("FAIL oor write done: got %0d want 1", o.done_cnt); end
        do_req(2, 1, 0, 9'h0AB, 32'h0, o);
        exp = model_step(2, 1, 0, 9'h0AB, 32'h0);
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL oor alias kept: got %0h want %0h", o.rd_final, exp); end
        do_req(2, 1, 0, 9'h1AB, 32'h0, o);
        exp = model_step(2, 1, 0, 9'h1AB, 32'h0);
        total++;
        if (o.rd_final !== exp) begin bad++; $display("FAIL oor read zero: got %0h want %0h", o.rd_final, exp); end
        total++;
        if (o.done_at !== 2) begin bad++; $display("FAIL oor read latency: got %0d want 2", o.done_at); end
    endtask

    task automatic test_random();
        logic [8:0]  pool [8];
        obs_t        o;
        logic [31:0] exp;
        logic [31:0] wd;
        logic [8:0]  a;
        bit          rd;
        bit          wr;
        int          r;
        pool = '{9'h000, 9'h001, 9'h07F, 9'h0FF, 9'h100, 9'h155, 9'h1FE, 9'h1FF};
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 25; i++) begin
                r  = int'($urandom_range(0, 99));
                a  = pool[$urandom_range(0, 7)];
                wd = $urandom;
                rd = (r >= 45);
                wr = (r < 45) || (r >= 90);
                if (rd && int'(a) < DEP_OF[d] && !known[d][int'(a)]) begin
                    rd = 1'b0;
                    wr = 1'b1;
                end
                do_req(d, rd, wr, a, wd, o);
                exp = model_step(d, rd, wr, a, wd);
                total++;
                if (o.done_at !== LAT_OF[d] + 1 || o.done_cnt !== 1) begin
                    bad++;
                    $display("FAIL rand d%0d done: got at=%0d n=%0d want at=%0d n=1",
                             d, o.done_at, o.done_cnt, LAT_OF[d] + 1);
                end
                total++;
                if (o.busy_cnt !== LAT_OF[d] + 1) begin
                    bad++;
                    $display("FAIL rand d%0d busy: got %0d want %0d", d, o.busy_cnt, LAT_OF[d] + 1);
                end
                total++;
                if (o.err_cnt !== ((rd && wr) ? 1 : 0)) begin
                    bad++;
                    $display("FAIL rand d%0d req_err: got %0d want %0d", d, o.err_cnt, (rd && wr) ? 1 : 0);
                end
                total++;
                if (o.hold_ok !== 1'b1 || o.rd_final !== exp) begin
                    bad++;
                    $display("FAIL rand d%0d rd_data: got %0h hold=%0b want %0h hold=1",
                             d, o.rd_final, o.hold_ok, exp);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            clr[d] = 1'b1; addr[d] = '0; wdat[d] = '0; read[d] = 1'b0; write[d] = 1'b0;
            last_rd[d] = 32'h0;
            for (int k = 0; k < 512; k++) begin
                mdl[d][k]   = 32'h0;
                known[d][k] = 1'b0;
            end
        end
        #3;
        for (int d = 0; d < 3; d++) clr[d] = 1'b0;
        test_reset();
        test_default_read();
        test_zero_latency();
        test_simultaneous();
        test_busy_ignore();
        test_reset_mid();
        test_hold();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2: wait cycles inserted before each access, legal range 0-15.
REQ-002 SHALL have parameter DEPTH, default 512: number of 32-bit words, matching the 9-bit MAR.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port clr, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mar_addr, input, 9: word address, driven from MAR.
REQ-006 SHALL have port wr_data, input, 32: write data, driven from MDR.
REQ-007 SHALL have port read, input, 1: read request, level-sampled.
REQ-008 SHALL have port write, input, 1: write request, level-sampled.
REQ-009 SHALL have port rd_data, output, 32: read data, driven to the MDR input multiplexer.
REQ-010 SHALL have port busy, output, 1: high while a request is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port req_err, output, 1: one-cycle pulse flagging simultaneous read and write.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS and DONE.
REQ-014 SHALL accept a request only in IDLE.
  - mar_addr, wr_data and the operation are latched at the accepting edge N.
  - busy rises after edge N.
REQ-015 SHALL load the wait counter with LATENCY at acceptance and hold WAIT while the counter is nonzero, decrementing once per cycle.
  - LATENCY=0 goes directly to ACCESS.
REQ-016 SHALL perform the array access at edge N+LATENCY+1 and assert done for exactly the cycle following that edge (state DONE).
REQ-017 SHALL return to IDLE from DONE.
  - busy falls with done.
  - A new request can be accepted at the edge ending DONE plus one, i.e. there is no back-to-back acceptance in DONE.
REQ-018 SHALL, for a read, update rd_data at the access edge and hold it unchanged until the next read completes.
  - Writes never alter rd_data.
REQ-019 SHALL, for a write, update the array at the access edge.
  - A read of the same address accepted afterwards returns the new value.
REQ-020 SHALL ignore read and write while busy is high; no queuing, no error.
REQ-021 SHALL, when read and write are both high in IDLE:
  - service the read;
  - drop the write;
  - pulse req_err in the cycle after acceptance.
REQ-022 SHALL ignore mar_addr values at or above DEPTH on writes and return 0 on reads; both still complete with done.

Reset
REQ-023 SHALL, while clr=0:
  - force state IDLE, rd_data=0, busy=0, done=0, req_err=0 and wait counter 0;
  - abort any in-progress request with no array write and no done.
REQ-024 SHALL NOT clear or initialise array contents on reset.
REQ-025 SHALL accept a new request at the first rising edge with clr=1.

Structure
REQ-026 SHALL place the following in shared package mem_pkg, reused by the datapath:
  - ADDR_W=9;
  - DATA_W=32;
  - the state enumeration;
  - the maximum LATENCY constant.
REQ-027 SHALL instantiate one sub-module, ram_512x32: a synchronous single-port array with write enable, holding the storage.
REQ-028 SHALL keep the FSM, counter and latches in memory_responder itself.

Verification
REQ-029 Read at default latency: write 0xDEADBEEF to address 0x005, then read address 0x005 with LATENCY=2 -> done high exactly 3 cycles after acceptance, rd_data=0xDEADBEEF, busy high for 3 cycles.
REQ-030 Zero latency: LATENCY=0, write 0x12345678 to address 0x1FF then read it -> done 1 cycle after each acceptance, rd_data=0x12345678.
REQ-031 Simultaneous request: read=write=1 at address 0x010 (pre-written 0x0000AAAA), wr_data=0xFFFFFFFF -> rd_data=0x0000AAAA, req_err pulses once, and a later read still returns 0x0000AAAA.
REQ-032 Request while busy: issue read of address 0x020, then a write request during WAIT -> write ignored, exactly one done, array unchanged.
REQ-033 Reset mid-operation: assert clr=0 during WAIT of a write of 0x5A5A5A5A to address 0x030 -> outputs zero immediately, no done, address 0x030 keeps its old value; read accepted on the first edge after release.
REQ-034 Hold behaviour: a write following a read -> rd_data keeps the prior read value throughout.
